// File: rtl/req_encoder_16to4_if.sv
// Request-encoder bus: request/mask inputs, flush and acknowledge controls,
// and the registered grant/pending outputs.
interface req_encoder_16to4_if #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
);
    logic [NUM_REQ-1:0] Req_In;
    logic [NUM_REQ-1:0] Mask_In;
    logic               Clear_All;
    logic               Enc_Ack;
    logic               Enc_Valid;
    logic [IDX_W-1:0]   Enc_Out;
    logic [NUM_REQ-1:0] Enc_Onehot;
    logic [NUM_REQ-1:0] Pending_Out;

    modport master (
        output Req_In, Mask_In, Clear_All, Enc_Ack,
        input  Enc_Valid, Enc_Out, Enc_Onehot, Pending_Out
    );

    modport slave (
        input  Req_In, Mask_In, Clear_All, Enc_Ack,
        output Enc_Valid, Enc_Out, Enc_Onehot, Pending_Out
    );
endinterface

// File: rtl/req_encoder_16to4.sv
// Sequential 16-to-4 priority encoder with rising-edge request capture and valid/ack handshake.
// Define REQ_ENC_ROUND_ROBIN_EN to rotate the search start past the last acknowledged index.
module req_encoder_16to4 #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    req_encoder_16to4_if.slave   bus
);

    // state     | meaning
    // S_IDLE    | no grant shown; selects from pending & mask each clock
    // S_PRESENT | grant held stable until Enc_Ack or Clear_All
    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_req_q;
    logic [NUM_REQ-1:0] r_pending;
    logic               r_valid;
    logic [IDX_W-1:0]   r_enc_out;
    logic [NUM_REQ-1:0] r_onehot;

    logic [NUM_REQ-1:0] w_rise;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_pend_nxt;
    logic               w_valid_nxt;
    logic [IDX_W-1:0]   w_out_nxt;
    logic [NUM_REQ-1:0] w_onehot_nxt;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_cand;
    logic               w_ack_take;

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   r_last_grant;
`endif

    assign w_rise     = bus.Req_In & ~r_req_q;
    assign w_elig     = r_pending & bus.Mask_In;
    assign w_ack_take = (r_state == S_PRESENT) && bus.Enc_Ack && !bus.Clear_All;

    // First eligible line found walking upward from the search start, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef REQ_ENC_ROUND_ROBIN_EN
            w_cand = r_last_grant + IDX_W'(1) + IDX_W'(k);
`else
            w_cand = IDX_W'(k);
`endif
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_out_nxt    = r_enc_out;
        w_onehot_nxt = r_onehot;
        w_pend_nxt   = r_pending | w_rise;
        if (bus.Clear_All) begin
            w_state_nxt  = S_IDLE;
            w_valid_nxt  = 1'b0;
            w_out_nxt    = '0;
            w_onehot_nxt = '0;
            w_pend_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        w_state_nxt  = S_PRESENT;
                        w_valid_nxt  = 1'b1;
                        w_out_nxt    = w_sel;
                        w_onehot_nxt = NUM_REQ'(1) << w_sel;
                    end
                end
                S_PRESENT: begin
                    if (bus.Enc_Ack) begin
                        w_state_nxt  = S_IDLE;
                        w_valid_nxt  = 1'b0;
                        w_out_nxt    = '0;
                        w_onehot_nxt = '0;
                        // a same-cycle rising edge on the acked line re-sets it
                        w_pend_nxt   = (r_pending & ~r_onehot) | w_rise;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_enc_out <= '0;
            r_onehot  <= '0;
        end else begin
            r_req_q   <= bus.Req_In;
            r_pending <= w_pend_nxt;
            r_valid   <= w_valid_nxt;
            r_enc_out <= w_out_nxt;
            r_onehot  <= w_onehot_nxt;
        end
    end

`ifdef REQ_ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= '1;
        end else if (w_ack_take) begin
            r_last_grant <= r_enc_out;
        end
    end
`endif

    assign bus.Enc_Valid   = r_valid;
    assign bus.Enc_Out     = r_enc_out;
    assign bus.Enc_Onehot  = r_onehot;
    assign bus.Pending_Out = r_pending;

endmodule

// File: tb/tb_req_encoder_16to4.sv
// Bench for req_encoder_16to4: directed handshake scenarios followed by random traffic,
// all outputs checked every clock against a behavioural model of pending set and grant.
module tb_req_encoder_16to4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    req_encoder_16to4_if bus ();
    req_encoder_16to4 dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] m_pend;
    logic [15:0] m_reqq;
    logic        m_valid;
    int          m_idx;
    int          m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_reqq  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 15;
    endtask

    // Index of the first set bit met when scanning upward from 'start', wrapping around.
    function automatic int pick(input logic [15:0] elig, input int start);
        logic [31:0] dbl;
        logic [15:0] rot;
        int n;
        dbl = {elig, elig};
        rot = 16'(dbl >> start);
        n = 0;
        while (n < 16 && !rot[n]) n++;
        return (n + start) % 16;
    endfunction

    task automatic model_update(input logic [15:0] req, input logic [15:0] mask,
                                input logic clr, input logic ack);
        logic [15:0] rise;
        logic [15:0] elig;
        int start;
        rise = req & ~m_reqq;
        if (clr) begin
            m_pend  = '0;
            m_valid = 1'b0;
            m_idx   = 0;
        end else if (m_valid) begin
            if (ack) begin
                m_pend  = (m_pend & ~(16'd1 << m_idx)) | rise;
                m_last  = m_idx;
                m_valid = 1'b0;
                m_idx   = 0;
            end else begin
                m_pend = m_pend | rise;
            end
        end else begin
            elig = m_pend & mask;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            start = (m_last + 1) % 16;
`else
            start = 0;
`endif
            if (elig != 0) begin
                m_idx   = pick(elig, start);
                m_valid = 1'b1;
            end
            m_pend = m_pend | rise;
        end
        m_reqq = req;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   32'(bus.Enc_Valid),   32'(m_valid));
        chk({tag, ".out"},     32'(bus.Enc_Out),     m_valid ? m_idx : 0);
        chk({tag, ".onehot"},  32'(bus.Enc_Onehot),  m_valid ? (32'd1 << m_idx) : 32'd0);
        chk({tag, ".pending"}, 32'(bus.Pending_Out), 32'(m_pend));
    endtask

    task automatic step(input logic [15:0] req, input logic [15:0] mask,
                        input logic clr, input logic ack, input string tag);
        bus.Req_In    = req;
        bus.Mask_In   = mask;
        bus.Clear_All = clr;
        bus.Enc_Ack   = ack;
        @(posedge clk);
        model_update(req, mask, clr, ack);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] r_req;
        logic [15:0] r_mask;
        bus.Req_In    = '0;
        bus.Mask_In   = 16'hFFFF;
        bus.Clear_All = 1'b0;
        bus.Enc_Ack   = 1'b0;
        reset = 1'b1;
        model_reset();
        #12;
        chk("rst.valid",   32'(bus.Enc_Valid),   0);
        chk("rst.out",     32'(bus.Enc_Out),     0);
        chk("rst.onehot",  32'(bus.Enc_Onehot),  0);
        chk("rst.pending", 32'(bus.Pending_Out), 0);
        @(negedge clk);
        reset = 1'b0;

        // two requests granted lowest first, each gap visits IDLE
        step(16'h0000, 16'hFFFF, 0, 0, "idle");
        step(16'h8010, 16'hFFFF, 0, 0, "cap");
        chk("cap.pend_const", 32'(bus.Pending_Out), 32'h8010);
        step(16'h8010, 16'hFFFF, 0, 0, "grant4");
        chk("grant4.out_const", 32'(bus.Enc_Out), 4);
        step(16'h8010, 16'hFFFF, 0, 1, "ack4");
        chk("ack4.valid_const", 32'(bus.Enc_Valid), 0);
        step(16'h8010, 16'hFFFF, 0, 0, "grant15");
        chk("grant15.onehot_const", 32'(bus.Enc_Onehot), 32'h8000);
        step(16'h8010, 16'hFFFF, 0, 1, "ack15");
        chk("ack15.pend_const", 32'(bus.Pending_Out), 0);

        // masked pending is retained, then granted once unmasked
        step(16'h0000, 16'hFFFF, 0, 0, "drop");
        step(16'h0010, 16'hFFEF, 0, 0, "mcap");
        step(16'h0010, 16'hFFEF, 0, 0, "mhold1");
        step(16'h0010, 16'hFFEF, 0, 0, "mhold2");
        chk("mhold.valid_const", 32'(bus.Enc_Valid), 0);
        step(16'h0010, 16'hFFFF, 0, 0, "unmask");
        chk("unmask.out_const", 32'(bus.Enc_Out), 4);
        step(16'h0010, 16'hFFFF, 0, 1, "unmask_ack");

        // rising edge on bit 3 in its own ack cycle keeps it pending
        step(16'h0018, 16'hFFFF, 0, 0, "b3cap");
        step(16'h0018, 16'hFFFF, 0, 0, "b3grant");
        step(16'h0010, 16'hFFFF, 0, 0, "b3low");
        step(16'h0018, 16'hFFFF, 0, 1, "b3ackrise");
        chk("b3ackrise.pend3_const", 32'(bus.Pending_Out[3]), 1);
        step(16'h0018, 16'hFFFF, 0, 0, "b3again");
        chk("b3again.out_const", 32'(bus.Enc_Out), 3);
        step(16'h0018, 16'hFFFF, 0, 1, "b3ack2");

        // Clear_All flushes grant and pending; a following ack is ignored
        step(16'h001E, 16'hFFFF, 0, 0, "ccap");
        step(16'h001E, 16'hFFFF, 0, 0, "cgrant1");
        step(16'h001E, 16'hFFFF, 1, 0, "clear");
        chk("clear.pend_const", 32'(bus.Pending_Out), 0);
        step(16'h001E, 16'hFFFF, 0, 1, "stray_ack");
        chk("stray_ack.valid_const", 32'(bus.Enc_Valid), 0);

        // bits 0 and 1 pending after acking 0 decides fixed vs rotating order
        step(16'h0000, 16'hFFFF, 0, 0, "rrdrop");
        step(16'h0003, 16'hFFFF, 0, 0, "rrcap");
        step(16'h0003, 16'hFFFF, 0, 0, "rrgrant0");
        step(16'h0002, 16'hFFFF, 0, 0, "rrlow");
        step(16'h0003, 16'hFFFF, 0, 1, "rrack0");
        step(16'h0003, 16'hFFFF, 0, 0, "rrnext");
`ifdef REQ_ENC_ROUND_ROBIN_EN
        chk("rrnext.out_const", 32'(bus.Enc_Out), 1);
`else
        chk("rrnext.out_const", 32'(bus.Enc_Out), 0);
`endif
        step(16'h0003, 16'hFFFF, 0, 1, "rrack");
        step(16'h0003, 16'hFFFF, 0, 0, "rrlast");
        step(16'h0003, 16'hFFFF, 0, 1, "rrack2");

        // asynchronous reset in the middle of a presented grant
        step(16'h0103, 16'hFFFF, 0, 0, "mrcap");
        step(16'h0103, 16'hFFFF, 0, 0, "mrgrant");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        reset = 1'b0;
        step(16'h0103, 16'hFFFF, 0, 0, "postrst");
        chk("postrst.pend_const", 32'(bus.Pending_Out), 32'h0103);
        step(16'h0103, 16'hFFFF, 0, 0, "postrst_grant");

        // random traffic
        r_req  = 16'h0103;
        r_mask = 16'hFFFF;
        for (int i = 0; i < 400; i++) begin
            r_req = r_req ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) r_mask = 16'($urandom | $urandom);
            step(r_req, r_mask, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
